// File: rtl/gray_pkg.sv
// Shared encodings and weight constants for the gray stream converter.
package gray_pkg;

   typedef enum logic [1:0] {
      MODE_BT601 = 2'b00,
      MODE_AVG   = 2'b01,
      MODE_PROG  = 2'b10,
      MODE_GREEN = 2'b11
   } mode_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int unsigned BT601_R_PM = 299;
   localparam int unsigned BT601_G_PM = 587;
   localparam int unsigned BT601_B_PM = 114;

   // Round-to-nearest of a per-mille luma factor scaled by 2^coef_w.
   function automatic int unsigned bt601_w(input int unsigned permille,
                                           input int unsigned coef_w);
      return (permille * (32'd1 << coef_w) + 32'd500) / 32'd1000;
   endfunction

   function automatic int unsigned avg_w(input int unsigned coef_w);
      return (32'd1 << coef_w) / 32'd3;
   endfunction

endpackage

// File: rtl/gray_mac.sv
// Combinational weighted sum of one RGB pixel with rounding and saturation.
module gray_mac #(
   parameter int DATA_W = 8,
   parameter int COEF_W = 8
) (
   input  logic [DATA_W-1:0] r,
   input  logic [DATA_W-1:0] g,
   input  logic [DATA_W-1:0] b,
   input  logic [COEF_W-1:0] wr,
   input  logic [COEF_W-1:0] wg,
   input  logic [COEF_W-1:0] wb,
   input  logic              passthrough,
   output logic [DATA_W-1:0] gray
);

   // Two guard bits cover the sum of three full-scale products plus rounding.
   localparam int ACC_W = DATA_W + COEF_W + 2;

   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] rounded;
   logic [ACC_W-1:0] scaled;

   always_comb begin
      acc     = ACC_W'(wr) * ACC_W'(r) + ACC_W'(wg) * ACC_W'(g) + ACC_W'(wb) * ACC_W'(b);
      rounded = acc + (ACC_W'(1) << (COEF_W - 1));
      scaled  = rounded >> COEF_W;
      if (passthrough) begin
         gray = g;
      end else if (|scaled[ACC_W-1:DATA_W]) begin
         gray = '1;
      end else begin
         gray = scaled[DATA_W-1:0];
      end
   end

endmodule

// File: rtl/gray_stream_converter.sv
// Byte-serial RGB to gray stream converter with a one-entry output slot
// and frame-level busy/done handshake to the controller.
module gray_stream_converter
   import gray_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int COEF_W = 8,
   parameter int IMG_W  = 2,
   parameter int IMG_H  = 2,
   localparam int NPIX  = IMG_W * IMG_H,
   localparam int CNT_W = $clog2(NPIX + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [1:0]        mode,
   input  logic [COEF_W-1:0] coef_r,
   input  logic [COEF_W-1:0] coef_g,
   input  logic [COEF_W-1:0] coef_b,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  pix_count,
   output state_t            fsm_state
);

   localparam logic [COEF_W-1:0] W601_R = COEF_W'(bt601_w(BT601_R_PM, COEF_W));
   localparam logic [COEF_W-1:0] W601_G = COEF_W'(bt601_w(BT601_G_PM, COEF_W));
   localparam logic [COEF_W-1:0] W601_B = COEF_W'(bt601_w(BT601_B_PM, COEF_W));
   localparam logic [COEF_W-1:0] W_AVG  = COEF_W'(avg_w(COEF_W));

   state_t            state;
   state_t            state_next;
   logic [1:0]        ch_cnt;
   logic [CNT_W-1:0]  in_pix;
   logic [DATA_W-1:0] r_q;
   logic [DATA_W-1:0] g_q;
   mode_t             mode_q;
   logic [COEF_W-1:0] cr_q;
   logic [COEF_W-1:0] cg_q;
   logic [COEF_W-1:0] cb_q;
   logic [COEF_W-1:0] wr;
   logic [COEF_W-1:0] wg;
   logic [COEF_W-1:0] wb;
   logic [DATA_W-1:0] gray;
   logic              in_hs;
   logic              b_hs;
   logic              out_hs;

   // A transfer happens on a rising edge where valid and ready are both high;
   // valid never waits for ready, and a held output stays stable until taken.
   assign in_hs     = in_valid & in_ready;
   assign b_hs      = in_hs & (ch_cnt == 2'd2);
   assign out_hs    = out_valid & out_ready;
   assign fsm_state = state;

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:  if (start) state_next = ST_RUN;
         ST_RUN:   if (b_hs && in_pix == CNT_W'(NPIX - 1)) state_next = ST_DRAIN;
         ST_DRAIN: if (out_hs && pix_count == CNT_W'(NPIX - 1)) state_next = ST_DONE;
         ST_DONE:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // The blue byte may only enter when the output slot can take its result.
   always_comb begin
      in_ready = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      case (state)
         ST_RUN: begin
            in_ready = (ch_cnt != 2'd2) || !out_valid || out_ready;
            busy     = 1'b1;
         end
         ST_DRAIN: busy = 1'b1;
         ST_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      wr = W601_R;
      wg = W601_G;
      wb = W601_B;
      case (mode_q)
         MODE_AVG: begin
            wr = W_AVG;
            wg = W_AVG;
            wb = W_AVG;
         end
         MODE_PROG: begin
            wr = cr_q;
            wg = cg_q;
            wb = cb_q;
         end
         default: ;
      endcase
   end

   gray_mac #(
      .DATA_W (DATA_W),
      .COEF_W (COEF_W)
   ) u_mac (
      .r           (r_q),
      .g           (g_q),
      .b           (in_data),
      .wr          (wr),
      .wg          (wg),
      .wb          (wb),
      .passthrough (mode_q == MODE_GREEN),
      .gray        (gray)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         ch_cnt    <= 2'd0;
         in_pix    <= '0;
         r_q       <= '0;
         g_q       <= '0;
         mode_q    <= MODE_BT601;
         cr_q      <= '0;
         cg_q      <= '0;
         cb_q      <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         pix_count <= '0;
      end else begin
         if (state == ST_IDLE && start) begin
            mode_q    <= mode_t'(mode);
            cr_q      <= coef_r;
            cg_q      <= coef_g;
            cb_q      <= coef_b;
            ch_cnt    <= 2'd0;
            in_pix    <= '0;
            pix_count <= '0;
         end
         if (in_hs) begin
            case (ch_cnt)
               2'd0: begin
                  r_q    <= in_data;
                  ch_cnt <= 2'd1;
               end
               2'd1: begin
                  g_q    <= in_data;
                  ch_cnt <= 2'd2;
               end
               default: begin
                  ch_cnt <= 2'd0;
                  in_pix <= in_pix + CNT_W'(1);
               end
            endcase
         end
         if (b_hs) begin
            out_valid <= 1'b1;
            out_data  <= gray;
         end else if (out_hs) begin
            out_valid <= 1'b0;
         end
         if (out_hs) pix_count <= pix_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_gray_stream_converter.sv
// Randomised frame-level bench for gray_stream_converter against a luma model.
module tb_gray_stream_converter;
   import gray_pkg::*;

   localparam int NPIX   = 4;
   localparam int BUDGET = 1000;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [1:0] mode;
   logic [7:0] coef_r;
   logic [7:0] coef_g;
   logic [7:0] coef_b;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       busy;
   logic       done;
   logic [2:0] pix_count;
   state_t     fsm_state;

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_q[$];
   int px_r[NPIX];
   int px_g[NPIX];
   int px_b[NPIX];
   logic [1:0] cur_m;
   int cur_cr;
   int cur_cg;
   int cur_cb;

   always #5 clk = ~clk;

   gray_stream_converter dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .mode      (mode),
      .coef_r    (coef_r),
      .coef_g    (coef_g),
      .coef_b    (coef_b),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy),
      .done      (done),
      .pix_count (pix_count),
      .fsm_state (fsm_state)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Luma as a weighted average in plain integer arithmetic, rounded, clipped at 255.
   function automatic int ref_gray(input logic [1:0] m, input int cr, input int cg, input int cb,
                                   input int r, input int g, input int b);
      int wr, wg, wb, q;
      case (m)
         2'd0:    begin wr = 77; wg = 150; wb = 29; end
         2'd1:    begin wr = 85; wg = 85;  wb = 85; end
         2'd2:    begin wr = cr; wg = cg;  wb = cb; end
         default: return g;
      endcase
      q = (wr * r + wg * g + wb * b + 128) / 256;
      return (q > 255) ? 255 : q;
   endfunction

   function automatic int pix_gray(input int p);
      return ref_gray(cur_m, cur_cr, cur_cg, cur_cb, px_r[p], px_g[p], px_b[p]);
   endfunction

   task automatic set_px(input int p, input int r, input int g, input int b);
      px_r[p] = r;
      px_g[p] = g;
      px_b[p] = b;
   endtask

   task automatic rand_px(input int from);
      for (int p = from; p < NPIX; p++)
         set_px(p, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
   endtask

   function automatic logic [7:0] byte_of(input int idx);
      int p = idx / 3;
      case (idx % 3)
         0:       return 8'(px_r[p]);
         1:       return 8'(px_g[p]);
         default: return 8'(px_b[p]);
      endcase
   endfunction

   task automatic drive_frame(input bit gaps, input bit rand_start);
      int idx = 0;
      int cyc = 0;
      int lat_pix = -1;
      while (idx < 3 * NPIX && cyc < BUDGET) begin
         @(negedge clk);
         if (lat_pix >= 0) begin
            check("latency_valid", 32'(out_valid), 32'd1);
            check("latency_data", 32'(out_data), 32'(pix_gray(lat_pix)));
            lat_pix = -1;
         end
         in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
         in_data  = byte_of(idx);
         if (rand_start) start = ($urandom_range(0, 5) == 0);
         #1;
         if (in_valid && in_ready) begin
            if (idx % 3 == 2) lat_pix = idx / 3;
            idx++;
         end
         cyc++;
      end
      @(negedge clk);
      if (lat_pix >= 0) begin
         check("latency_valid", 32'(out_valid), 32'd1);
         check("latency_data", 32'(out_data), 32'(pix_gray(lat_pix)));
      end
      in_valid = 1'b0;
      start    = 1'b0;
      check("bytes_accepted", 32'(idx), 32'(3 * NPIX));
   endtask

   // policy 0: sink always ready, 1: random, 2: stalled for the first 12 cycles
   task automatic monitor_frame(input int policy);
      int got = 0;
      int cyc = 0;
      int done_seen = 0;
      logic [7:0] exp;
      while (got < NPIX && cyc < BUDGET) begin
         @(negedge clk);
         if (done) done_seen++;
         case (policy)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 2) != 0);
            default: out_ready = (cyc >= 12);
         endcase
         #1;
         if (policy == 2 && (cyc == 5 || cyc == 10)) begin
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_pix_count", 32'(pix_count), 32'd0);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_output", 32'(got), 32'(NPIX));
            end else begin
               exp = exp_q.pop_front();
               check("out_data", 32'(out_data), 32'(exp));
            end
            got++;
         end
         cyc++;
      end
      check("outputs_per_frame", 32'(got), 32'(NPIX));
      @(negedge clk);
      out_ready = 1'b0;
      check("done_early", 32'(done_seen), 32'd0);
      check("done_pulse", 32'(done), 32'd1);
      check("busy_at_done", 32'(busy), 32'd0);
      check("pix_count_final", 32'(pix_count), 32'(NPIX));
      @(negedge clk);
      check("done_single", 32'(done), 32'd0);
      check("idle_after_done", 32'(fsm_state), 32'(ST_IDLE));
      check("pix_count_hold", 32'(pix_count), 32'(NPIX));
      check("queue_empty", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic run_frame(input logic [1:0] m, input int cr, input int cg, input int cb,
                            input bit gaps, input int policy, input bit rand_start);
      cur_m  = m;
      cur_cr = cr;
      cur_cg = cg;
      cur_cb = cb;
      exp_q.delete();
      for (int p = 0; p < NPIX; p++) exp_q.push_back(8'(pix_gray(p)));
      @(negedge clk);
      mode   = m;
      coef_r = 8'(cr);
      coef_g = 8'(cg);
      coef_b = 8'(cb);
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      // Scramble the configuration inputs; the frame must use the latched values.
      mode   = 2'($urandom_range(0, 3));
      coef_r = 8'($urandom_range(0, 255));
      coef_g = 8'($urandom_range(0, 255));
      coef_b = 8'($urandom_range(0, 255));
      check("busy_after_start", 32'(busy), 32'd1);
      fork
         drive_frame(gaps, rand_start);
         monitor_frame(policy);
      join
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
      check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_out_data"}, 32'(out_data), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_pix_count"}, 32'(pix_count), 32'd0);
      check({tag, "_state"}, 32'(fsm_state), 32'(ST_IDLE));
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; mode = 2'd0;
      coef_r = '0; coef_g = '0; coef_b = '0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;

      set_px(0, 100, 50, 200);
      set_px(1, 255, 255, 255);
      rand_px(2);
      run_frame(2'd0, 0, 0, 0, 1'b0, 0, 1'b0);

      set_px(0, 90, 90, 90);
      rand_px(1);
      run_frame(2'd1, 0, 0, 0, 1'b1, 1, 1'b0);

      set_px(0, 10, 77, 3);
      rand_px(1);
      run_frame(2'd3, 0, 0, 0, 1'b1, 1, 1'b0);

      set_px(0, 255, 255, 255);
      rand_px(1);
      run_frame(2'd2, 255, 255, 255, 1'b0, 0, 1'b0);

      rand_px(0);
      run_frame(2'd2, 0, 0, 0, 1'b1, 1, 1'b0);

      rand_px(0);
      run_frame(2'd0, 0, 0, 0, 1'b0, 2, 1'b0);

      for (int f = 0; f < 4; f++) begin
         rand_px(0);
         run_frame(2'($urandom_range(0, 3)), $urandom_range(0, 255), $urandom_range(0, 255),
                   $urandom_range(0, 255), 1'b1, 1, 1'b1);
      end

      // Reset after the green byte of pixel 2, with pixel 1's result still held.
      set_px(0, 100, 50, 200);
      rand_px(1);
      cur_m = 2'd0;
      @(negedge clk);
      mode = 2'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0; out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_data  = byte_of(i);
         @(negedge clk);
      end
      in_valid = 1'b0;
      check("pre_reset_out_valid", 32'(out_valid), 32'd1);
      check("pre_reset_out_data", 32'(out_data), 32'(pix_gray(0)));
      rst = 1'b1;
      @(negedge clk);
      check_all_zero("mid_reset");
      rst = 1'b0;

      rand_px(0);
      run_frame(2'd0, 0, 0, 0, 1'b1, 1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
